// File: rtl/bios_mem_pkg.sv
// Shared constants and types for the BIOS RAM arbiter slice.
package bios_mem_pkg;

  localparam int MEM_WORDS_DEF = 128;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; last_grant moves to the winner
// whenever a grant is taken.
module rr_arb2
  import bios_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic req_d,
  input  logic take,
  output logic gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt = PORT_D;
    if (req_i && req_d)
      gnt = (last_q == PORT_D) ? PORT_I : PORT_D;
    else if (req_i)
      gnt = PORT_I;
    last_d = take ? gnt : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= PORT_D;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/bios_ram_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one
// external single-port BIOS RAM: IDLE -> ISSUE -> RESP per access.
module bios_ram_arbiter
  import bios_mem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int ADDR_W    = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [47:0]       ram_dout
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_WORDS);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic              oor_q, oor_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;

  logic gnt;
  logic take;
  logic resp;
  logic rd_ok;
  logic [15:0] unused_dout_hi;

  assign take = (state_q == S_IDLE) && (i_req || d_req);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (i_req),
    .req_d (d_req),
    .take  (take),
    .gnt   (gnt)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    oor_d      = oor_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          owner_d = gnt;
          if (gnt == PORT_D) begin
            ram_addr_d = d_addr;
            ram_din_d  = d_wdata;
            wr_d       = d_we;
            oor_d      = (d_addr >= LIMIT);
          end else begin
            ram_addr_d = i_addr;
            ram_din_d  = '0;
            wr_d       = 1'b0;
            oor_d      = (i_addr >= LIMIT);
          end
          // Write strobe is live for the whole ISSUE cycle.
          ram_we_d = wr_d && !oor_d;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= PORT_D;
      wr_q       <= 1'b0;
      oor_q      <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      oor_q      <= oor_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
    end
  end

  assign resp  = (state_q == S_RESP);
  assign i_ack = resp && (owner_q == PORT_I);
  assign d_ack = resp && (owner_q == PORT_D);
  assign d_err = d_ack && oor_q;

  // Gate the RAM bus so a Z after a write never leaks out.
  assign rd_ok   = resp && !wr_q && !oor_q;
  assign i_rdata = (rd_ok && owner_q == PORT_I) ? ram_dout[31:0] : 32'h0;
  assign d_rdata = (rd_ok && owner_q == PORT_D) ? ram_dout[31:0] : 32'h0;

  assign unused_dout_hi = ram_dout[47:32];

  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_we   = ram_we_q;

endmodule

// File: tb/tb_bios_ram_arbiter.sv
// Bench for bios_ram_arbiter: external RAM model, transaction-level
// reference model checked every cycle, directed and random traffic.
module tb_bios_ram_arbiter;

  localparam int AW = 20;
  localparam int MW = 128;

  logic          clk;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ack;
  logic [31:0]   d_rdata;
  logic          d_err;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic          ram_we;
  logic [47:0]   ram_dout;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int we_cnt = 0;

  logic [31:0] mem [MW];
  logic [31:0] ref_mem [MW];

  bios_ram_arbiter #(.MEM_WORDS(MW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // External synchronous RAM: Z on the read bus after a write.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      mem[ram_addr[6:0]] = ram_din;
      ram_dout <= 'z;
    end else begin
      ram_dout <= {16'hBAD0, mem[ram_addr[6:0]]};
    end
  end

  // Reference model: one transaction at a time, granted in an idle
  // cycle (age 0), ack two cycles later (age 2).
  bit            m_busy = 0;
  bit            m_own_d = 0;
  bit            m_wr = 0;
  bit            m_oor = 0;
  bit            m_last_d = 1;
  int            m_age = 0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_wdata = '0;

  always @(negedge clk) begin : model
    logic e_iack, e_dack, e_we;
    logic [31:0] e_ird, e_drd;
    if (rst) begin
      m_busy   = 0;
      m_last_d = 1;
      chk("rst_ctl", 64'({i_ack, d_ack, d_err, ram_we}), 64'd0);
      chk("rst_bus", 64'({ram_addr, ram_din}), 64'd0);
      chk("rst_rdata", {i_rdata, d_rdata}, 64'd0);
    end else begin
      e_iack = m_busy && m_age == 2 && !m_own_d;
      e_dack = m_busy && m_age == 2 && m_own_d;
      e_we   = m_busy && m_age == 1 && m_own_d && m_wr && !m_oor;
      e_ird  = (e_iack && !m_oor) ? ref_mem[m_addr[6:0]] : 32'h0;
      e_drd  = (e_dack && !m_wr && !m_oor) ? ref_mem[m_addr[6:0]] : 32'h0;
      chk("acks", 64'({i_ack, d_ack}), 64'({e_iack, e_dack}));
      chk("d_err", 64'(d_err), 64'(e_dack && m_oor));
      chk("ram_we", 64'(ram_we), 64'(e_we));
      chk("i_rdata", 64'(i_rdata), 64'(e_ird));
      chk("d_rdata", 64'(d_rdata), 64'(e_drd));
      if (m_busy && m_age == 1)
        chk("ram_addr", 64'(ram_addr), 64'(m_addr));
      if (e_we)
        chk("ram_din", 64'(ram_din), 64'(m_wdata));
      if (ram_we) we_cnt++;
      if (m_busy) begin
        if (e_we) ref_mem[m_addr[6:0]] = m_wdata;
        if (m_age == 2) m_busy = 0;
        else m_age++;
      end else if (i_req || d_req) begin
        m_own_d  = (i_req && d_req) ? !m_last_d : d_req;
        m_last_d = m_own_d;
        m_addr   = m_own_d ? d_addr : i_addr;
        m_wr     = m_own_d && d_we;
        m_wdata  = d_wdata;
        m_oor    = (m_addr >= AW'(MW));
        m_busy   = 1;
        m_age    = 1;
      end
    end
  end

  task automatic do_i(input logic [AW-1:0] a, output logic [31:0] rd,
                      output int lat);
    int t0;
    bit got;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = a;
    t0 = cyc; got = 0; lat = -1; rd = 'x;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (i_ack) begin got = 1; rd = i_rdata; lat = cyc - t0; end
    end
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic do_d(input logic we, input logic [AW-1:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic err, output int lat);
    int t0;
    bit got;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    t0 = cyc; got = 0; lat = -1; rd = 'x; err = 'x;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (d_ack) begin
        got = 1; rd = d_rdata; err = d_err; lat = cyc - t0;
      end
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  initial begin : stim
    logic [31:0] rd;
    logic err;
    int lat, w0, t0, nacks;
    int ack_cyc[4];
    bit ack_d[4];
    bit ia, da;

    rst = 1'b1;
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    for (int k = 0; k < MW; k++) begin
      mem[k] = 32'h0101_0101 * k + 32'h5000_0000;
      ref_mem[k] = mem[k];
    end
    mem[5] = 32'hDEADBEEF;  ref_mem[5] = 32'hDEADBEEF;
    mem[72] = 32'h7272_7272; ref_mem[72] = 32'h7272_7272;
    mem[3] = 32'h3333_3333;  ref_mem[3] = 32'h3333_3333;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    w0 = we_cnt;
    do_i(20'd5, rd, lat);
    chk("i5_lat", 64'(lat), 64'd2);
    chk("i5_data", 64'(rd), 64'hDEADBEEF);
    chk("i5_no_we", 64'(we_cnt - w0), 64'd0);

    do_d(1'b1, 20'd10, 32'h12345678, rd, err, lat);
    chk("w10_lat", 64'(lat), 64'd2);
    chk("w10_rdata", 64'(rd), 64'd0);
    chk("w10_err", 64'(err), 64'd0);
    do_d(1'b0, 20'd10, 32'h0, rd, err, lat);
    chk("r10_data", 64'(rd), 64'h12345678);
    chk("r10_err", 64'(err), 64'd0);

    w0 = we_cnt;
    do_d(1'b1, 20'd200, 32'hFFFFFFFF, rd, err, lat);
    chk("w200_lat", 64'(lat), 64'd2);
    chk("w200_err", 64'(err), 64'd1);
    chk("w200_no_we", 64'(we_cnt - w0), 64'd0);
    chk("mem72", 64'(mem[72]), 64'h72727272);

    do_i(20'd128, rd, lat);
    chk("i128_lat", 64'(lat), 64'd2);
    chk("i128_data", 64'(rd), 64'd0);

    // Tie after reset: I wins first, then strict alternation.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    i_req = 1; i_addr = 20'd7;
    d_req = 1; d_we = 0; d_addr = 20'd8;
    t0 = cyc; nacks = 0;
    for (int k = 0; k < 20 && nacks < 4; k++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        ack_cyc[nacks] = cyc - t0;
        ack_d[nacks] = d_ack;
        nacks++;
      end
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    chk("tie_count", 64'(nacks), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk("tie_cycle", 64'(ack_cyc[k]), 64'(2 + 3 * k));
      chk("tie_owner", 64'(ack_d[k]), 64'(k % 2));
    end

    // Reset caught in ISSUE of a write to addr 3.
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_addr = 20'd3; d_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("rst_issue_we", 64'(ram_we), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_we_now", 64'(ram_we), 64'd0);
    chk("rst_dack_now", 64'(d_ack), 64'd0);
    @(posedge clk); #1 d_req = 0;
    @(posedge clk); #1 rst = 1'b0;
    nacks = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (d_ack) nacks++;
    end
    chk("rst_no_dack", 64'(nacks), 64'd0);
    chk("mem3", 64'(mem[3]), 64'h33333333);
    do_i(20'd3, rd, lat);
    chk("post_rst_lat", 64'(lat), 64'd2);
    chk("post_rst_data", 64'(rd), 64'h33333333);

    // Random traffic; the model process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ia = i_ack; da = d_ack;
      @(posedge clk); #1;
      if (i_req && !ia) begin
        if ($urandom_range(0, 19) == 0) i_req = 0;
      end else begin
        i_req = ($urandom_range(0, 2) != 0);
        i_addr = AW'($urandom_range(0, 199));
      end
      if (d_req && !da) begin
        if ($urandom_range(0, 19) == 0) d_req = 0;
      end else begin
        d_req = ($urandom_range(0, 2) != 0);
        d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom_range(0, 199));
        d_wdata = $urandom;
      end
    end
    i_req = 0; d_req = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
